alu_mc: RTL and testbench

Parametrised multi-cycle ALU for the 54-instruction CPU datapath: all single-cycle integer ops of the existing ALU at generic width `W`, plus iterative MULT/MULTU/DIV/DIVU with architectural HI/LO registers and MTHI/MTLO/MFHI/MFLO. It sits in the execute stage. The control unit stalls on `in_ready` low, and consumes the registered result and flags on `out_valid`.

---
 rtl/alu_pkg.sv | 38 +++
 rtl/mdu_core.sv | 125 ++++++++++++
 rtl/alu_mc.sv | 246 ++++++++++++++++++++++++
 tb/tb_alu_mc.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared op codes and FSM state encoding for the multi-cycle ALU.
package alu_pkg;

   // Single-cycle ops: op[4]=0, op[3:0] is the legacy aluc field
   localparam logic [4:0] OP_ADDU  = 5'b00000;
   localparam logic [4:0] OP_SUBU  = 5'b00001;
   localparam logic [4:0] OP_ADD   = 5'b00010;
   localparam logic [4:0] OP_SUB   = 5'b00011;
   localparam logic [4:0] OP_AND   = 5'b00100;
   localparam logic [4:0] OP_OR    = 5'b00101;
   localparam logic [4:0] OP_XOR   = 5'b00110;
   localparam logic [4:0] OP_NOR   = 5'b00111;
   localparam logic [4:0] OP_LUI   = 5'b01000;   // 0100x
   localparam logic [4:0] OP_SLTU  = 5'b01010;
   localparam logic [4:0] OP_SLT   = 5'b01011;
   localparam logic [4:0] OP_SRA   = 5'b01100;
   localparam logic [4:0] OP_SRL   = 5'b01101;
   localparam logic [4:0] OP_SLL   = 5'b01110;   // 0111x

   // Multiply/divide and HI/LO moves: op[4]=1
   localparam logic [4:0] OP_MULT  = 5'b10000;
   localparam logic [4:0] OP_MULTU = 5'b10001;
   localparam logic [4:0] OP_DIV   = 5'b10010;
   localparam logic [4:0] OP_DIVU  = 5'b10011;
   localparam logic [4:0] OP_MTHI  = 5'b10100;
   localparam logic [4:0] OP_MTLO  = 5'b10101;
   localparam logic [4:0] OP_MFHI  = 5'b10110;
   localparam logic [4:0] OP_MFLO  = 5'b10111;
   localparam logic [4:0] OP_RSVD  = 5'b11000;   // 11xxx

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_MUL   = 2'd1,
      ST_DIV   = 2'd2,
      ST_DONE1 = 2'd3
   } state_t;

endpackage

// File: rtl/mdu_core.sv
// Iterative radix-2 multiply/divide engine: shift-add multiply and restoring
// divide on operand magnitudes, one step per cycle, W steps per operation.
// Sign correction is applied combinationally on the outputs once idle.
module mdu_core #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic         signed_op,
   input  logic         is_div,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] hi_out,
   output logic [W-1:0] lo_out,
   output logic         dz
);

   localparam int CW = $clog2(W);

   logic          busy_reg;
   logic [CW-1:0] cnt_reg;
   logic          div_reg;
   logic          neg_q_reg;     // product / quotient must be negated
   logic          neg_r_reg;     // remainder takes the dividend's sign
   logic          dz_reg;
   logic [W-1:0]  acc_hi_reg;    // product high half / partial remainder
   logic [W-1:0]  acc_lo_reg;    // multiplier bits / dividend-quotient
   logic [W-1:0]  opnd_reg;      // multiplicand magnitude / divisor magnitude
   logic [W-1:0]  a_orig_reg;    // dividend as issued, returned on divide by zero

   logic          a_neg, b_neg;
   logic [W-1:0]  a_mag, b_mag;
   logic [W-1:0]  step_hi_next, step_lo_next;
   logic [W:0]    mul_add;
   logic [W:0]    div_shift;
   logic [2*W-1:0] prod_fix;
   logic [W-1:0]  q_fix, r_fix;

   assign a_neg = signed_op & a[W-1];
   assign b_neg = signed_op & b[W-1];
   assign a_mag = a_neg ? -a : a;
   assign b_mag = b_neg ? -b : b;

   assign mul_add   = {1'b0, acc_hi_reg} + (acc_lo_reg[0] ? {1'b0, opnd_reg} : '0);
   assign div_shift = {acc_hi_reg, acc_lo_reg[W-1]};

   // One iteration step: add-and-shift-right, or shift-left-and-trial-subtract
   always_comb begin
      step_hi_next = acc_hi_reg;
      step_lo_next = acc_lo_reg;
      if (div_reg) begin
         if (div_shift >= {1'b0, opnd_reg}) begin
            step_hi_next = div_shift[W-1:0] - opnd_reg;
            step_lo_next = {acc_lo_reg[W-2:0], 1'b1};
         end else begin
            step_hi_next = div_shift[W-1:0];
            step_lo_next = {acc_lo_reg[W-2:0], 1'b0};
         end
      end else begin
         step_hi_next = mul_add[W:1];
         step_lo_next = {mul_add[0], acc_lo_reg[W-1:1]};
      end
   end

   // Operand load on start, then W iteration steps; reset aborts mid-flight
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy_reg   <= 1'b0;
         cnt_reg    <= '0;
         div_reg    <= 1'b0;
         neg_q_reg  <= 1'b0;
         neg_r_reg  <= 1'b0;
         dz_reg     <= 1'b0;
         acc_hi_reg <= '0;
         acc_lo_reg <= '0;
         opnd_reg   <= '0;
         a_orig_reg <= '0;
      end else if (start && !busy_reg) begin
         busy_reg   <= 1'b1;
         cnt_reg    <= '0;
         div_reg    <= is_div;
         neg_q_reg  <= a_neg ^ b_neg;
         neg_r_reg  <= a_neg;
         dz_reg     <= is_div && (b == '0);
         acc_hi_reg <= '0;
         acc_lo_reg <= a_mag;
         opnd_reg   <= b_mag;
         a_orig_reg <= a;
      end else if (busy_reg) begin
         acc_hi_reg <= step_hi_next;
         acc_lo_reg <= step_lo_next;
         cnt_reg    <= cnt_reg + 1'b1;
         if (cnt_reg == CW'(W-1)) begin
            busy_reg <= 1'b0;
         end
      end
   end

   assign prod_fix = neg_q_reg ? -{acc_hi_reg, acc_lo_reg} : {acc_hi_reg, acc_lo_reg};
   assign q_fix    = neg_q_reg ? -acc_lo_reg : acc_lo_reg;
   assign r_fix    = neg_r_reg ? -acc_hi_reg : acc_hi_reg;

   // Sign-corrected results; divide by zero forces all-ones quotient, remainder = a
   always_comb begin
      hi_out = prod_fix[2*W-1:W];
      lo_out = prod_fix[W-1:0];
      if (div_reg) begin
         if (dz_reg) begin
            hi_out = a_orig_reg;
            lo_out = '1;
         end else begin
            hi_out = r_fix;
            lo_out = q_fix;
         end
      end
   end

   assign busy = busy_reg;
   assign done = busy_reg && (cnt_reg == CW'(W-1));
   assign dz   = dz_reg;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle execute-stage ALU: single-cycle integer ops, iterative
// multiply/divide through mdu_core, and the architectural HI/LO registers.
module alu_mc
   import alu_pkg::*;
#(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [4:0]   op,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         out_valid,
   output logic [W-1:0] r,
   output logic         zero,
   output logic         carry,
   output logic         negative,
   output logic         overflow,
   output logic [W-1:0] hi,
   output logic [W-1:0] lo
);

   localparam int SW = $clog2(W);

   state_t        state_reg, state_next;
   logic [4:0]    op_reg;
   logic [W-1:0]  a_reg, b_reg;
   logic [W-1:0]  r_reg, hi_reg, lo_reg;
   logic          zero_reg, carry_reg, negative_reg, overflow_reg, out_valid_reg;

   logic          accept, mdu_start, mdu_busy, mdu_done, mdu_dz;
   logic [W-1:0]  mdu_hi, mdu_lo;

   logic [SW-1:0] sh;
   logic [W:0]    add_ext, srl_ext, sra_ext, sll_ext;
   logic [W-1:0]  sub_res;
   logic          min_by_neg1;

   logic [W-1:0]  res_next, hi_next, lo_next;
   logic          zero_next, carry_next, negative_next, overflow_next, zn_std;

   assign in_ready  = (state_reg == ST_IDLE) && !mdu_busy;
   assign accept    = in_valid && in_ready;
   assign mdu_start = accept && (op[4:2] == 3'b100);

   mdu_core #(.W(W)) u_mdu (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (mdu_start),
      .signed_op (!op[0]),
      .is_div    (op[1]),
      .a         (a),
      .b         (b),
      .busy      (mdu_busy),
      .done      (mdu_done),
      .hi_out    (mdu_hi),
      .lo_out    (mdu_lo),
      .dz        (mdu_dz)
   );

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next state: single-cycle ops go straight to DONE1, mul/div iterate first
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: begin
            if (accept) begin
               if (mdu_start) begin
                  state_next = op[1] ? ST_DIV : ST_MUL;
               end else begin
                  state_next = ST_DONE1;
               end
            end
         end
         ST_MUL, ST_DIV: begin
            if (mdu_done) begin
               state_next = ST_DONE1;
            end
         end
         ST_DONE1: state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   // Capture the request so inputs may change while the op is in flight
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         op_reg <= '0;
         a_reg  <= '0;
         b_reg  <= '0;
      end else if (accept) begin
         op_reg <= op;
         a_reg  <= a;
         b_reg  <= b;
      end
   end

   // Shifts carry one guard bit so the last bit shifted out falls out for free
   assign sh          = a_reg[SW-1:0];
   assign add_ext     = {1'b0, a_reg} + {1'b0, b_reg};
   assign sub_res     = a_reg - b_reg;
   assign srl_ext     = {b_reg, 1'b0} >> sh;
   assign sra_ext     = $signed({b_reg, 1'b0}) >>> sh;
   assign sll_ext     = {1'b0, b_reg} << sh;
   assign min_by_neg1 = (a_reg == {1'b1, {(W-1){1'b0}}}) && (b_reg == '1);

   // Result, flags and HI/LO update for the op currently in DONE1
   always_comb begin
      res_next      = '0;
      zero_next     = 1'b0;
      carry_next    = 1'b0;
      negative_next = 1'b0;
      overflow_next = 1'b0;
      zn_std        = 1'b1;
      hi_next       = hi_reg;
      lo_next       = lo_reg;
      casez (op_reg)
         OP_ADDU: begin
            res_next   = add_ext[W-1:0];
            carry_next = add_ext[W];
         end
         OP_SUBU: begin
            res_next   = sub_res;
            carry_next = (a_reg < b_reg);
         end
         OP_ADD: begin
            res_next      = add_ext[W-1:0];
            overflow_next = (a_reg[W-1] == b_reg[W-1]) && (add_ext[W-1] != a_reg[W-1]);
         end
         OP_SUB: begin
            res_next      = sub_res;
            overflow_next = (a_reg[W-1] != b_reg[W-1]) && (sub_res[W-1] != a_reg[W-1]);
         end
         OP_AND: res_next = a_reg & b_reg;
         OP_OR:  res_next = a_reg | b_reg;
         OP_XOR: res_next = a_reg ^ b_reg;
         OP_NOR: res_next = ~(a_reg | b_reg);
         5'b0100?: res_next = {b_reg[W/2-1:0], {(W/2){1'b0}}};
         OP_SLTU: begin
            zn_std        = 1'b0;
            res_next      = {{(W-1){1'b0}}, (a_reg < b_reg)};
            carry_next    = (a_reg < b_reg);
            zero_next     = (a_reg == b_reg);
            negative_next = 1'b0;
         end
         OP_SLT: begin
            zn_std        = 1'b0;
            res_next      = {{(W-1){1'b0}}, ($signed(a_reg) < $signed(b_reg))};
            zero_next     = (a_reg == b_reg);
            negative_next = ($signed(a_reg) < $signed(b_reg));
         end
         OP_SRA: begin
            res_next   = sra_ext[W:1];
            carry_next = sra_ext[0];
         end
         OP_SRL: begin
            res_next   = srl_ext[W:1];
            carry_next = srl_ext[0];
         end
         5'b0111?: begin
            res_next   = sll_ext[W-1:0];
            carry_next = sll_ext[W];
         end
         OP_MULT, OP_MULTU: begin
            zn_std        = 1'b0;
            res_next      = mdu_lo;
            hi_next       = mdu_hi;
            lo_next       = mdu_lo;
            zero_next     = ({mdu_hi, mdu_lo} == '0);
            negative_next = mdu_hi[W-1];
         end
         OP_DIV: begin
            res_next      = mdu_lo;
            hi_next       = mdu_hi;
            lo_next       = mdu_lo;
            overflow_next = mdu_dz || min_by_neg1;
         end
         OP_DIVU: begin
            res_next      = mdu_lo;
            hi_next       = mdu_hi;
            lo_next       = mdu_lo;
            overflow_next = mdu_dz;
         end
         OP_MTHI: begin
            res_next = a_reg;
            hi_next  = a_reg;
         end
         OP_MTLO: begin
            res_next = a_reg;
            lo_next  = a_reg;
         end
         OP_MFHI: res_next = hi_reg;
         OP_MFLO: res_next = lo_reg;
         default: zn_std = 1'b0;   // reserved 11xxx: zero result, no flags
      endcase
      if (zn_std) begin
         zero_next     = (res_next == '0);
         negative_next = res_next[W-1];
      end
   end

   // Output and HI/LO registers commit on leaving DONE1
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_reg <= 1'b0;
         r_reg         <= '0;
         zero_reg      <= 1'b0;
         carry_reg     <= 1'b0;
         negative_reg  <= 1'b0;
         overflow_reg  <= 1'b0;
         hi_reg        <= '0;
         lo_reg        <= '0;
      end else begin
         out_valid_reg <= (state_reg == ST_DONE1);
         if (state_reg == ST_DONE1) begin
            r_reg        <= res_next;
            zero_reg     <= zero_next;
            carry_reg    <= carry_next;
            negative_reg <= negative_next;
            overflow_reg <= overflow_next;
            hi_reg       <= hi_next;
            lo_reg       <= lo_next;
         end
      end
   end

   assign out_valid = out_valid_reg;
   assign r         = r_reg;
   assign zero      = zero_reg;
   assign carry     = carry_reg;
   assign negative  = negative_reg;
   assign overflow  = overflow_reg;
   assign hi        = hi_reg;
   assign lo        = lo_reg;

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc at W=32 and W=16: the driver pushes the
// expected response per request, per-DUT monitors pop and compare on out_valid.
module tb_alu_mc;
   import alu_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        in_valid, in_ready, out_valid;
   logic [4:0]  op;
   logic [31:0] a, b, r, hi, lo;
   logic        zero, carry, negative, overflow;

   logic        in_valid_16, in_ready_16, out_valid_16;
   logic [4:0]  op_16;
   logic [15:0] a_16, b_16, r_16, hi_16, lo_16;
   logic        zero_16, carry_16, negative_16, overflow_16;

   alu_mc #(.W(32)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .a(a), .b(b), .out_valid(out_valid), .r(r),
      .zero(zero), .carry(carry), .negative(negative), .overflow(overflow),
      .hi(hi), .lo(lo)
   );

   alu_mc #(.W(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_16), .in_ready(in_ready_16),
      .op(op_16), .a(a_16), .b(b_16), .out_valid(out_valid_16), .r(r_16),
      .zero(zero_16), .carry(carry_16), .negative(negative_16), .overflow(overflow_16),
      .hi(hi_16), .lo(lo_16)
   );

   typedef struct {
      logic [31:0] r;
      logic [3:0]  f;     // {zero, carry, negative, overflow}
      logic [31:0] hi;
      logic [31:0] lo;
      int          lat;
      int          t_acc;
   } exp_t;

   exp_t  q32[$];
   exp_t  q16[$];
   string n32[$];
   string n16[$];

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [31:0] m_hi32, m_lo32, m_hi16, m_lo16;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask

   // Monitor for the 32-bit DUT
   exp_t  e32;
   string s32;
   always @(negedge clk) begin
      if (out_valid === 1'b1) begin
         if (q32.size() == 0) begin
            chk("unexpected_out_valid32", 32'd1, 32'd0);
         end else begin
            e32 = q32.pop_front();
            s32 = n32.pop_front();
            chk({s32, "_r"}, r, e32.r);
            chk({s32, "_flags"}, {28'h0, zero, carry, negative, overflow}, {28'h0, e32.f});
            chk({s32, "_hi"}, hi, e32.hi);
            chk({s32, "_lo"}, lo, e32.lo);
            chk({s32, "_lat"}, cyc - e32.t_acc, e32.lat);
            $display("txn W32 %s r=%h zcnv=%b%b%b%b hi=%h lo=%h", s32, r,
                     zero, carry, negative, overflow, hi, lo);
         end
      end
   end

   // Monitor for the 16-bit DUT
   exp_t  e16;
   string s16;
   always @(negedge clk) begin
      if (out_valid_16 === 1'b1) begin
         if (q16.size() == 0) begin
            chk("unexpected_out_valid16", 32'd1, 32'd0);
         end else begin
            e16 = q16.pop_front();
            s16 = n16.pop_front();
            chk({s16, "_r"}, {16'h0, r_16}, e16.r);
            chk({s16, "_flags"}, {28'h0, zero_16, carry_16, negative_16, overflow_16}, {28'h0, e16.f});
            chk({s16, "_hi"}, {16'h0, hi_16}, e16.hi);
            chk({s16, "_lo"}, {16'h0, lo_16}, e16.lo);
            chk({s16, "_lat"}, cyc - e16.t_acc, e16.lat);
            $display("txn W16 %s r=%h zcnv=%b%b%b%b hi=%h lo=%h", s16, r_16,
                     zero_16, carry_16, negative_16, overflow_16, hi_16, lo_16);
         end
      end
   end

   // Called at a negedge; waits for ready, issues, pushes expectation, returns at a negedge.
   // wr=1 means this op writes HI/LO with ehi/elo, otherwise the model values are expected.
   task automatic issue(input int sel, input string nm, input logic [4:0] o,
                        input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] er, input logic [3:0] ef,
                        input logic wr, input logic [31:0] ehi, input logic [31:0] elo,
                        input int lat);
      int   guard;
      exp_t e;
      guard = 0;
      while (((sel == 0) ? !in_ready : !in_ready_16) && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 200) chk({nm, "_ready_timeout"}, 32'd0, 32'd1);
      if (sel == 0) begin
         if (wr) begin m_hi32 = ehi; m_lo32 = elo; end
         e.hi = m_hi32; e.lo = m_lo32;
         in_valid = 1'b1; op = o; a = x; b = y;
      end else begin
         if (wr) begin m_hi16 = ehi; m_lo16 = elo; end
         e.hi = m_hi16; e.lo = m_lo16;
         in_valid_16 = 1'b1; op_16 = o; a_16 = x[15:0]; b_16 = y[15:0];
      end
      e.r = er; e.f = ef; e.lat = lat;
      @(posedge clk);
      #1;
      e.t_acc = cyc;
      if (sel == 0) begin q32.push_back(e); n32.push_back(nm); end
      else          begin q16.push_back(e); n16.push_back(nm); end
      in_valid    = 1'b0;
      in_valid_16 = 1'b0;
      @(negedge clk);
   endtask

   int lowc;
   int ovc;
   int guard;

   initial begin
      rst_n = 1'b0;
      in_valid = 1'b0; op = '0; a = '0; b = '0;
      in_valid_16 = 1'b0; op_16 = '0; a_16 = '0; b_16 = '0;
      m_hi32 = '0; m_lo32 = '0; m_hi16 = '0; m_lo16 = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready",  {31'h0, in_ready}, 32'd1);
      chk("rst_out_valid", {31'h0, out_valid}, 32'd0);
      chk("rst_r",         r, 32'd0);
      chk("rst_flags",     {28'h0, zero, carry, negative, overflow}, 32'd0);
      chk("rst_hi",        hi, 32'd0);
      chk("rst_lo",        lo, 32'd0);
      chk("rst16_hilo",    {hi_16, lo_16}, 32'd0);
      chk("rst16_ready",   {31'h0, in_ready_16}, 32'd1);
      rst_n = 1'b1;
      @(negedge clk);

      // Single-cycle ops, flags {z,c,n,v}
      issue(0, "add_ovf", OP_ADD, 32'h7FFFFFFF, 32'h1, 32'h80000000, 4'b0011, 0, 0, 0, 1);
      lowc = 0;
      while (!in_ready && lowc < 100) begin lowc++; @(negedge clk); end
      chk("add_ready_low", lowc, 1);
      issue(0, "addu_cy",  OP_ADDU, 32'hFFFFFFFF, 32'h1, 32'h0, 4'b1100, 0, 0, 0, 1);
      issue(0, "subu_bor", OP_SUBU, 32'h1, 32'h2, 32'hFFFFFFFF, 4'b0110, 0, 0, 0, 1);
      issue(0, "sub_ovf",  OP_SUB, 32'h80000000, 32'h1, 32'h7FFFFFFF, 4'b0001, 0, 0, 0, 1);
      issue(0, "and",      OP_AND, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 4'b0000, 0, 0, 0, 1);
      issue(0, "nor",      OP_NOR, 32'h0, 32'h0, 32'hFFFFFFFF, 4'b0010, 0, 0, 0, 1);
      issue(0, "lui",      OP_LUI, 32'h0, 32'h00001234, 32'h12340000, 4'b0000, 0, 0, 0, 1);
      issue(0, "slt",      OP_SLT, 32'hFFFFFFFF, 32'h1, 32'h1, 4'b0010, 0, 0, 0, 1);
      issue(0, "sltu_eq",  OP_SLTU, 32'h5, 32'h5, 32'h0, 4'b1000, 0, 0, 0, 1);
      issue(0, "sra",      OP_SRA, 32'h4, 32'h80000018, 32'hF8000001, 4'b0110, 0, 0, 0, 1);
      issue(0, "sll_sh0",  OP_SLL, 32'h0, 32'h80000001, 32'h80000001, 4'b0010, 0, 0, 0, 1);
      issue(0, "srl",      OP_SRL, 32'h1, 32'h3, 32'h1, 4'b0100, 0, 0, 0, 1);

      // MULT with an MTHI request held during busy that must be ignored
      issue(0, "mult", OP_MULT, 32'hFFFFFFFD, 32'h7, 32'hFFFFFFEB, 4'b0010, 1,
            32'hFFFFFFFF, 32'hFFFFFFEB, 33);
      lowc = 0;
      while (!in_ready && lowc < 100) begin
         lowc++;
         if (lowc < 20) begin in_valid = 1'b1; op = OP_MTHI; a = 32'h1234; end
         else in_valid = 1'b0;
         @(negedge clk);
      end
      in_valid = 1'b0;
      chk("mult_ready_low", lowc, 33);
      issue(0, "mfhi_after_mult", OP_MFHI, 32'h0, 32'h0, 32'hFFFFFFFF, 4'b0010, 0, 0, 0, 1);

      issue(0, "div",      OP_DIV, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFD, 4'b0010, 1,
            32'hFFFFFFFF, 32'hFFFFFFFD, 33);
      issue(0, "divu_dz",  OP_DIVU, 32'h5, 32'h0, 32'hFFFFFFFF, 4'b0011, 1,
            32'h5, 32'hFFFFFFFF, 33);
      issue(0, "divu",     OP_DIVU, 32'd100, 32'd7, 32'hE, 4'b0000, 1, 32'h2, 32'hE, 33);
      issue(0, "div_min",  OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 4'b0011, 1,
            32'h0, 32'h80000000, 33);
      issue(0, "mtlo",     OP_MTLO, 32'hCAFEF00D, 32'h0, 32'hCAFEF00D, 4'b0010, 1,
            32'h0, 32'hCAFEF00D, 1);
      issue(0, "mflo",     OP_MFLO, 32'h0, 32'h0, 32'hCAFEF00D, 4'b0010, 0, 0, 0, 1);
      issue(0, "mthi",     OP_MTHI, 32'h55, 32'h0, 32'h55, 4'b0000, 1, 32'h55, 32'hCAFEF00D, 1);

      // Reset during iteration 10 of a DIV aborts it and clears HI/LO
      guard = 0;
      while (!in_ready && guard < 100) begin guard++; @(negedge clk); end
      in_valid = 1'b1; op = OP_DIV; a = 32'd100; b = 32'd7;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort_in_ready",  {31'h0, in_ready}, 32'd1);
      chk("abort_out_valid", {31'h0, out_valid}, 32'd0);
      chk("abort_hi",        hi, 32'd0);
      chk("abort_lo",        lo, 32'd0);
      rst_n = 1'b1;
      m_hi32 = '0; m_lo32 = '0; m_hi16 = '0; m_lo16 = '0;
      ovc = 0;
      repeat (40) begin @(negedge clk); if (out_valid) ovc++; end
      chk("abort_no_out_valid", ovc, 0);

      issue(0, "mflo_cleared", OP_MFLO, 32'h0, 32'h0, 32'h0, 4'b1000, 0, 0, 0, 1);
      issue(0, "reserved",     OP_RSVD, 32'h5, 32'h5, 32'h0, 4'b0000, 0, 0, 0, 1);
      issue(0, "multu_zero",   OP_MULTU, 32'h0, 32'h5, 32'h0, 4'b1000, 1, 32'h0, 32'h0, 33);

      // W=16 instance
      issue(1, "w16_multu", OP_MULTU, 32'hFFFF, 32'hFFFF, 32'h0001, 4'b0010, 1,
            32'hFFFE, 32'h0001, 17);
      lowc = 0;
      while (!in_ready_16 && lowc < 100) begin lowc++; @(negedge clk); end
      chk("w16_ready_low", lowc, 17);
      issue(1, "w16_mfhi",  OP_MFHI, 32'h0, 32'h0, 32'hFFFE, 4'b0010, 0, 0, 0, 1);
      issue(1, "w16_div",   OP_DIV, 32'hFF9C, 32'h0007, 32'hFFF2, 4'b0010, 1,
            32'hFFFE, 32'hFFF2, 17);

      guard = 0;
      while ((q32.size() != 0 || q16.size() != 0) && guard < 200) begin
         guard++;
         @(negedge clk);
      end
      chk("q32_drained", q32.size(), 0);
      chk("q16_drained", q16.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
